// File: rtl/bsg_link_ds_pkg.sv
// Shared width helpers and word typedef for the multi-channel SDR downstream link.
package bsg_link_ds_pkg;

  localparam int DefChWidth = 8;
  localparam int DefPhases  = 2;

  typedef logic [DefChWidth*DefPhases-1:0] chan_word_t;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int phaseWidth(input int phases);
    return (phases > 1) ? $clog2(phases) : 1;
  endfunction

  function automatic int chanWordWidth(input int chWidth, input int phases);
    return chWidth * phases;
  endfunction

  function automatic int tokenWidth(input int decimation);
    return (decimation > 1) ? $clog2(decimation) : 1;
  endfunction

endpackage

// File: rtl/bsg_link_ds_chan_fifo.sv
// One receive path: gathers beats into a channel word and queues it in a FIFO.
module bsg_link_ds_chan_fifo
  import bsg_link_ds_pkg::*;
#(
  parameter int CH_WIDTH   = 8,
  parameter int PHASES     = 2,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         i_link_reset,
  input  logic                                         i_valid,
  input  logic [CH_WIDTH-1:0]                          i_data,
  input  logic                                         i_deq,
  output logic                                         o_not_empty,
  output logic [chanWordWidth(CH_WIDTH, PHASES)-1:0]   o_head,
  output logic                                         o_overflow
);

  localparam int PTR_W  = ptrWidth(FIFO_DEPTH);
  localparam int ADDR_W = PTR_W - 1;
  localparam int PH_W   = phaseWidth(PHASES);
  localparam int WORD_W = chanWordWidth(CH_WIDTH, PHASES);

  logic [PH_W-1:0]   r_ph;
  logic [WORD_W-1:0] r_gather;
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic              r_overflow;

  logic              w_last;
  logic              w_full;
  logic              w_empty;
  logic              w_complete;
  logic              w_enq;
  logic              w_drop;
  logic [WORD_W-1:0] w_word;

  assign w_last     = (r_ph == PH_W'(PHASES - 1));
  assign w_full     = ((r_wptr ^ r_rptr) == {1'b1, {ADDR_W{1'b0}}});
  assign w_empty    = (r_wptr == r_rptr);
  assign w_complete = i_valid & w_last;
  // A dequeue in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_enq      = w_complete & (~w_full | i_deq);
  assign w_drop     = w_complete & w_full & ~i_deq;

  always_comb begin
    w_word = r_gather;
    w_word[(PHASES-1)*CH_WIDTH +: CH_WIDTH] = i_data;
  end

  always_ff @(posedge clk) begin
    if (i_valid) begin
      r_gather[r_ph*CH_WIDTH +: CH_WIDTH] <= i_data;
    end
    if (w_enq) begin
      r_mem[r_wptr[ADDR_W-1:0]] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph       <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else if (i_link_reset) begin
      r_ph       <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_valid) begin
        r_ph <= w_last ? '0 : r_ph + 1'b1;
      end
      if (w_enq) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (i_deq) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_not_empty = ~w_empty;
  assign o_head      = r_mem[r_rptr[ADDR_W-1:0]];
  assign o_overflow  = r_overflow;

endmodule

// File: rtl/bsg_link_sdr_downstream_mc.sv
// Multi-channel downstream receiver: per-channel gather FIFOs, lock-step core dequeue, decimated credit tokens.
module bsg_link_sdr_downstream_mc
  import bsg_link_ds_pkg::*;
#(
  parameter int CHANNELS         = 2,
  parameter int CH_WIDTH         = 8,
  parameter int PHASES           = 2,
  parameter int FIFO_DEPTH       = 32,
  parameter int TOKEN_DECIMATION = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 link_reset_i,
  input  logic [CHANNELS-1:0]                  io_valid_i,
  input  logic [CHANNELS*CH_WIDTH-1:0]         io_data_i,
  output logic                                 core_valid_o,
  output logic [CHANNELS*PHASES*CH_WIDTH-1:0]  core_data_o,
  input  logic                                 core_yumi_i,
  output logic [CHANNELS-1:0]                  core_token_r_o,
  output logic [CHANNELS-1:0]                  overflow_o
);

  localparam int WORD_W = chanWordWidth(CH_WIDTH, PHASES);
  localparam int TOK_W  = tokenWidth(TOKEN_DECIMATION);

  logic [CHANNELS-1:0] w_notEmpty;
  logic                w_deq;
  logic                w_tokWrap;
  logic [TOK_W-1:0]    r_tokCnt;
  logic [CHANNELS-1:0] r_token;

  assign core_valid_o = &w_notEmpty;
  assign w_deq        = core_yumi_i & core_valid_o;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    bsg_link_ds_chan_fifo #(
      .CH_WIDTH   (CH_WIDTH),
      .PHASES     (PHASES),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_link_reset (link_reset_i),
      .i_valid      (io_valid_i[c]),
      .i_data       (io_data_i[c*CH_WIDTH +: CH_WIDTH]),
      .i_deq        (w_deq),
      .o_not_empty  (w_notEmpty[c]),
      .o_head       (core_data_o[c*WORD_W +: WORD_W]),
      .o_overflow   (overflow_o[c])
    );
  end

  // With a decimation of one the counter stays at zero and every dequeue wraps.
  assign w_tokWrap = (r_tokCnt == TOK_W'(TOKEN_DECIMATION - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tokCnt <= '0;
      r_token  <= '0;
    end else if (link_reset_i) begin
      r_tokCnt <= '0;
      r_token  <= '0;
    end else if (w_deq) begin
      r_tokCnt <= w_tokWrap ? '0 : r_tokCnt + 1'b1;
      if (w_tokWrap) begin
        r_token <= ~r_token;
      end
    end
  end

  assign core_token_r_o = r_token;

endmodule
